// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared constants, types and helpers for the BRAM read path
package bram_pkg;

  localparam int BRAM_DATA_W = 16;
  localparam int RAM_DEPTH   = 1024;
  localparam int RAM_AW      = 10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } burst_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// rtl/bram_rd_fifo.sv - generic synchronous show-ahead FIFO with push/pop/full/empty/level
module bram_rd_fifo
  import bram_pkg::*;
#(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              rdata,
  output logic                      full,
  output logic                      empty,
  output logic [clog2(DEPTH):0]     level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra MSB so full and empty differ when the low bits match.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/bram_rd_stream_buffer.sv
// rtl/bram_rd_stream_buffer.sv - buffers the BRAM read stream, re-emits it with valid/ready, reports burst stats
module bram_rd_stream_buffer
  import bram_pkg::*;
#(
  parameter int DATA_W = BRAM_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [clog2(DEPTH):0] level,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  burst_done,
  output logic [CNT_W-1:0]      burst_count,
  output logic [DATA_W-1:0]     burst_sum
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              fifo_full, fifo_empty;
  logic              push, pop, drop;
  logic [DATA_W:0]   fifo_rdata;

  bram_rd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_last, in_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // A pop frees a slot in the same cycle, so a full FIFO still accepts when the consumer drains.
  assign out_valid            = !fifo_empty;
  assign {out_last, out_data} = fifo_rdata;
  assign pop                  = !fifo_empty && out_ready;
  assign push                 = in_valid && (!fifo_full || pop);
  assign drop                 = in_valid && fifo_full && !pop;

  burst_state_e      state_q, state_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic [DATA_W-1:0] acc_sum_q, acc_sum_d;
  logic              overflow_q, overflow_d;
  logic              burst_done_q, burst_done_d;
  logic [CNT_W-1:0]  burst_count_q, burst_count_d;
  logic [DATA_W-1:0] burst_sum_q, burst_sum_d;
  logic [CNT_W-1:0]  base_cnt, beat_cnt;
  logic [DATA_W-1:0] base_sum, beat_sum;

  always_comb begin
    state_d       = state_q;
    acc_cnt_d     = acc_cnt_q;
    acc_sum_d     = acc_sum_q;
    burst_done_d  = 1'b0;
    burst_count_d = burst_count_q;
    burst_sum_d   = burst_sum_q;
    overflow_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

    base_cnt = (state_q == ST_ACTIVE) ? acc_cnt_q : '0;
    base_sum = (state_q == ST_ACTIVE) ? acc_sum_q : '0;
    beat_cnt = base_cnt;
    beat_sum = base_sum;
    if (push) begin
      beat_cnt = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CNT_ONE;
      beat_sum = base_sum + in_data;
    end

    // A closing beat reports totals even when the beat itself was dropped.
    if (in_valid && in_last) begin
      burst_done_d  = 1'b1;
      burst_count_d = beat_cnt;
      burst_sum_d   = beat_sum;
      acc_cnt_d     = '0;
      acc_sum_d     = '0;
      state_d       = ST_IDLE;
    end else if (push) begin
      acc_cnt_d = beat_cnt;
      acc_sum_d = beat_sum;
      state_d   = ST_ACTIVE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      acc_cnt_q     <= '0;
      acc_sum_q     <= '0;
      overflow_q    <= 1'b0;
      burst_done_q  <= 1'b0;
      burst_count_q <= '0;
      burst_sum_q   <= '0;
    end else begin
      state_q       <= state_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_sum_q     <= acc_sum_d;
      overflow_q    <= overflow_d;
      burst_done_q  <= burst_done_d;
      burst_count_q <= burst_count_d;
      burst_sum_q   <= burst_sum_d;
    end
  end

  assign overflow    = overflow_q;
  assign burst_done  = burst_done_q;
  assign burst_count = burst_count_q;
  assign burst_sum   = burst_sum_q;

endmodule

// File: tb/tb_bram_rd_stream_buffer.sv
// tb/tb_bram_rd_stream_buffer.sv - self-checking bench for bram_rd_stream_buffer
module tb_bram_rd_stream_buffer;

  localparam int DEPTH  = 8;
  localparam int CNT_W  = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic [3:0]  level;
  logic        overflow;
  logic        ovf_clr;
  logic        burst_done;
  logic [7:0]  burst_count;
  logic [15:0] burst_sum;

  bram_rd_stream_buffer #(.DATA_W(16), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .level       (level),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .burst_done  (burst_done),
    .burst_count (burst_count),
    .burst_sum   (burst_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: FIFO as a queue of {last,data}, stats as plain integers.
  logic [16:0] mq[$];
  int m_acc_cnt, m_acc_sum, m_cnt, m_sum;
  bit m_ovf, m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_acc_cnt = 0; m_acc_sum = 0; m_cnt = 0; m_sum = 0;
    m_ovf = 0; m_done = 0;
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("level", 32'(level), 32'(mq.size()));
    if (mq.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(mq[0][15:0]));
      chk("out_last", 32'(out_last), 32'(mq[0][16]));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("burst_done", 32'(burst_done), 32'(m_done));
    chk("burst_count", 32'(burst_count), 32'(m_cnt));
    chk("burst_sum", 32'(burst_sum), 32'(m_sum));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic iv, input logic [15:0] d, input logic l,
                      input logic rdy, input logic clr);
    bit pop, acc, drop;
    in_valid = iv; in_data = d; in_last = l; out_ready = rdy; ovf_clr = clr;
    #1;
    check_model();
    pop  = (mq.size() != 0) && rdy;
    acc  = iv && ((mq.size() < DEPTH) || pop);
    drop = iv && !acc;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back({l, d});
      m_acc_cnt = (m_acc_cnt < CNT_SAT) ? m_acc_cnt + 1 : CNT_SAT;
      m_acc_sum = (m_acc_sum + int'(d)) % 65536;
    end
    m_done = 0;
    if (iv && l) begin
      m_done = 1; m_cnt = m_acc_cnt; m_sum = m_acc_sum;
      m_acc_cnt = 0; m_acc_sum = 0;
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 16'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic async_reset();
    in_valid = 0; in_last = 0; out_ready = 0; ovf_clr = 0;
    #2 rst = 1'b0;
    #1 model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        l;
    logic        rdy;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_last;
    logic [3:0]  exp_level;
    logic        exp_done;
    logic [7:0]  exp_cnt;
    logic [15:0] exp_sum;
  } vec_t;

  vec_t vt[5];

  initial begin
    checks = 0; failures = 0;
    model_reset();
    rst = 1'b0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0; ovf_clr = 0;

    vt[0] = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 4'd1, 1'b0, 8'd0, 16'h0000};
    vt[1] = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 4'd1, 1'b0, 8'd0, 16'h0000};
    vt[2] = '{1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b0, 4'd1, 1'b0, 8'd0, 16'h0000};
    vt[3] = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 4'd1, 1'b1, 8'd4, 16'h0005};
    vt[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 8'd4, 16'h0005};

    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);

    for (int i = 0; i < 5; i++) begin
      step(vt[i].iv, vt[i].d, vt[i].l, vt[i].rdy, 1'b0);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].exp_valid));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].exp_level));
      if (vt[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].exp_data));
        chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(vt[i].exp_last));
      end
      chk($sformatf("vec%0d_done", i), 32'(burst_done), 32'(vt[i].exp_done));
      chk($sformatf("vec%0d_cnt", i), 32'(burst_count), 32'(vt[i].exp_cnt));
      chk($sformatf("vec%0d_sum", i), 32'(burst_sum), 32'(vt[i].exp_sum));
    end

    // Overfill: 10 words into an 8-deep FIFO with the consumer stalled.
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0010 + 16'(i), (i == 9), 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_done", 32'(burst_done), 32'd1);
    chk("ovf_count", 32'(burst_count), 32'd8);
    chk("ovf_sum", 32'(burst_sum), 32'h009C);

    // Full with simultaneous pop and push: accepted, level holds.
    step(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0);
    chk("fullpp_level", 32'(level), 32'd8);
    chk("fullpp_ovf", 32'(overflow), 32'd1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_alone", 32'(overflow), 32'd0);
    step(1'b1, 16'h0066, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_drop", 32'(overflow), 32'd1);
    for (int i = 0; i < 9; i++) idle(1'b1);
    step(1'b1, 16'h0077, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // Mid-burst reset, then a fresh 2-word burst.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, 1'b0);
    async_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(burst_count), 32'd0);
    step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h2000, 1'b1, 1'b0, 1'b0);
    chk("fresh_count", 32'(burst_count), 32'd2);
    chk("fresh_sum", 32'(burst_sum), 32'h3000);
    chk("fresh_head", 32'(out_data), 32'h1000);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Counter saturation on a long streamed burst.
    for (int i = 0; i < 300; i++) step(1'b1, 16'(i), (i == 299), 1'b1, 1'b0);
    chk("sat_count", 32'(burst_count), 32'(CNT_SAT));
    idle(1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
